fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 38 +++
 rtl/fetch_unit.sv | 87 ++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared ISA definitions: opcodes, instruction field positions and
// the fetch-to-decode bundle used by every CPU stage.
package fetch_unit_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LI  = 4'h1,
    OP_ADD = 4'h2,
    OP_JNZ = 4'h3,
    OP_JMP = 4'h4
  } opcode_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int TGT_MSB = 11;
  localparam int TGT_LSB = 4;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [15:0] op;
    logic [7:0]  pc;
    logic        valid;
  } if_id_t;

  function automatic logic [3:0] opc_of(
    input logic [15:0] w
  );
    return w[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [7:0] tgt_of(
    input logic [15:0] w
  );
    return w[TGT_MSB:TGT_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: registered fetch-to-decode slot with
// zero-bubble JMP predecode, execute redirect and self-loop halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'd0,
  parameter logic [3:0] OPC_JMP  = OP_JMP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  imem_pc,
  input  logic [15:0] imem_op,
  output logic [15:0] id_op,
  output logic [7:0]  id_pc,
  output logic        id_valid,
  input  logic        id_ready,
  input  logic        ex_redirect,
  input  logic [7:0]  ex_target,
  output logic        halted,
  output logic [15:0] fetch_cnt
);

  logic [7:0]  pc_q, pc_d;
  if_id_t      id_q, id_d;
  logic        halt_q, halt_d;
  logic [15:0] cnt_q, cnt_d;

  logic load;
  logic xfer;
  logic is_jmp;

  assign load   = !halt_q && (!id_q.valid || id_ready);
  assign xfer   = id_q.valid && id_ready;
  assign is_jmp = opc_of(imem_op) == OPC_JMP;

  always_comb begin
    pc_d   = pc_q;
    id_d   = id_q;
    halt_d = halt_q;
    cnt_d  = cnt_q;
    if (xfer && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 16'd1;
    // redirect outranks load, stall, halt and predecode
    priority case (1'b1)
      ex_redirect: begin
        pc_d       = ex_target;
        id_d.valid = 1'b0;
        halt_d     = 1'b0;
      end
      load: begin
        id_d.op    = imem_op;
        id_d.pc    = pc_q;
        id_d.valid = 1'b1;
        if (is_jmp) begin
          pc_d = tgt_of(imem_op);
          if (tgt_of(imem_op) == pc_q)
            halt_d = 1'b1;
        end else begin
          pc_d = pc_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      id_q   <= '0;
      halt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      id_q   <= id_d;
      halt_q <= halt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign imem_pc   = pc_q;
  assign id_op     = id_q.op;
  assign id_pc     = id_q.pc;
  assign id_valid  = id_q.valid;
  assign halted    = halt_q;
  assign fetch_cnt = cnt_q;

endmodule
